regfile_writer: RTL and testbench

REGFILE_WRITER -- requirements
Module: regfile_writer

---
 rtl/regfile_writer_pkg.sv | 17 +
 rtl/regfile_writer_wb_fifo.sv | 91 +++++++++
 rtl/regfile_writer.sv | 79 +++++++
 tb/tb_regfile_writer.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_writer_pkg.sv
// regfile_writer_pkg
// Shared widths, constants and the queue-entry record used by the register
// file writeback block and its multi-cycle result queue.
package regfile_writer_pkg;

    localparam int REG_W  = 5;
    localparam int DATA_W = 32;

    localparam logic [REG_W-1:0] ZERO_REG = '0;

    typedef struct packed {
        logic              valid;
        logic [REG_W-1:0]  dst;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/regfile_writer_wb_fifo.sv
// wb_fifo
// Ordered queue of multi-cycle results waiting for a register file write
// slot. Entries can be cancelled by destination register; survivors are
// repacked behind the read pointer so the queue never holds holes and the
// live count always equals the occupied slot count.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   push, push_reg/data   append an entry (caller guarantees count < DEPTH)
//   pop                   drop the head entry
//   kill, kill_reg        cancel every pre-existing entry for kill_reg
//   query_reg, hit        any live entry targets query_reg (combinational)
//   head                  oldest live entry; head.valid = queue non-empty
//   count                 live entries
module wb_fifo
    import regfile_writer_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [REG_W-1:0]  push_reg,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    input  logic              kill,
    input  logic [REG_W-1:0]  kill_reg,
    input  logic [REG_W-1:0]  query_reg,
    output logic              hit,
    output wb_entry_t         head,
    output logic [CW-1:0]     count
);

    wb_entry_t       mem     [DEPTH];
    wb_entry_t       mem_nxt [DEPTH];
    wb_entry_t       cur;
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   rd_nxt;
    logic [CW-1:0]   kept;

    // Walk the queue oldest-first; each survivor lands at rd_nxt + (number
    // of survivors before it). With no cancellations this leaves every
    // entry in its current slot, so only kills actually move data.
    always_comb begin
        mem_nxt = '{default: '0};
        cur     = '0;
        kept    = '0;
        rd_nxt  = rd_ptr + PW'(pop);
        for (int i = 0; i < DEPTH; i++) begin
            cur = mem[rd_ptr + PW'(i)];
            if (CW'(i) < count && cur.valid
                && !(pop && i == 0)
                && !(kill && cur.dst == kill_reg)) begin
                mem_nxt[rd_nxt + kept[PW-1:0]] = cur;
                kept = kept + CW'(1);
            end
        end
        // A same-cycle push is appended after the kill, so it survives.
        if (push) begin
            mem_nxt[rd_nxt + kept[PW-1:0]] = '{valid: 1'b1, dst: push_reg, data: push_data};
            kept = kept + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            mem    <= mem_nxt;
            rd_ptr <= rd_nxt;
            count  <= kept;
        end
    end

    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (mem[i].valid && mem[i].dst == query_reg && query_reg != ZERO_REG) begin
                hit = 1'b1;
            end
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/regfile_writer.sv
// regfile_writer
// Arbitrates the single register file write port between the pipeline ALU
// result (never stalled, highest priority) and queued multi-cycle results.
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   alu_valid/alu_reg/alu_data      pipeline writeback result
//   md_valid/md_reg/md_data/md_ready multi-cycle result handshake
//   pend_q, pend_hit                decode hazard query against the queue
//   RegWrite/writereg/writedata     registered register file write port
//   fifo_count                      live queued results
module regfile_writer
    import regfile_writer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   alu_valid,
    input  logic [REG_W-1:0]       alu_reg,
    input  logic [DATA_W-1:0]      alu_data,
    input  logic                   md_valid,
    input  logic [REG_W-1:0]       md_reg,
    input  logic [DATA_W-1:0]      md_data,
    output logic                   md_ready,
    input  logic [REG_W-1:0]       pend_q,
    output logic                   pend_hit,
    output logic                   RegWrite,
    output logic [REG_W-1:0]       writereg,
    output logic [DATA_W-1:0]      writedata,
    output logic [$clog2(DEPTH):0] fifo_count
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic      sel_alu;
    logic      pop;
    logic      push;
    wb_entry_t head;

    assign sel_alu  = alu_valid && (alu_reg != ZERO_REG);
    assign pop      = !sel_alu && head.valid;
    assign md_ready = fifo_count < CW'(DEPTH);
    // md results for r0 complete the handshake but are dropped here.
    assign push     = md_valid && md_ready && (md_reg != ZERO_REG);

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_reg  (md_reg),
        .push_data (md_data),
        .pop       (pop),
        .kill      (sel_alu),
        .kill_reg  (alu_reg),
        .query_reg (pend_q),
        .hit       (pend_hit),
        .head      (head),
        .count     (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            RegWrite  <= 1'b0;
            writereg  <= '0;
            writedata <= '0;
        end else if (sel_alu) begin
            RegWrite  <= 1'b1;
            writereg  <= alu_reg;
            writedata <= alu_data;
        end else if (pop) begin
            RegWrite  <= 1'b1;
            writereg  <= head.dst;
            writedata <= head.data;
        end else begin
            RegWrite  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_regfile_writer.sv
module tb_regfile_writer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid, md_valid, md_ready, pend_hit, RegWrite;
    logic [4:0]  alu_reg, md_reg, pend_q, writereg;
    logic [31:0] alu_data, md_data, writedata;
    logic [2:0]  fifo_count;

    always #5 clk = ~clk;

    regfile_writer #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .alu_valid  (alu_valid),
        .alu_reg    (alu_reg),
        .alu_data   (alu_data),
        .md_valid   (md_valid),
        .md_reg     (md_reg),
        .md_data    (md_data),
        .md_ready   (md_ready),
        .pend_q     (pend_q),
        .pend_hit   (pend_hit),
        .RegWrite   (RegWrite),
        .writereg   (writereg),
        .writedata  (writedata),
        .fifo_count (fifo_count)
    );

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Reference model: a plain queue of pending results plus the last write.
    typedef struct {
        logic [4:0]  r;
        logic [31:0] d;
    } ment_t;

    ment_t       q[$];
    ment_t       e;
    bit          acc;
    logic        m_we   = 1'b0;
    logic [4:0]  m_reg  = '0;
    logic [31:0] m_data = '0;

    function automatic bit model_hit(logic [4:0] r);
        if (r == 5'd0) return 1'b0;
        foreach (q[i]) if (q[i].r == r) return 1'b1;
        return 1'b0;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            m_we   = 1'b0;
            m_reg  = '0;
            m_data = '0;
        end else begin
            acc = md_valid && (q.size() < DEPTH);
            if (alu_valid && alu_reg != 5'd0) begin
                for (int i = q.size() - 1; i >= 0; i--) begin
                    if (q[i].r == alu_reg) q.delete(i);
                end
                m_we   = 1'b1;
                m_reg  = alu_reg;
                m_data = alu_data;
            end else if (q.size() > 0) begin
                e      = q.pop_front();
                m_we   = 1'b1;
                m_reg  = e.r;
                m_data = e.d;
            end else begin
                m_we = 1'b0;
            end
            if (acc && md_reg != 5'd0) begin
                e.r = md_reg;
                e.d = md_data;
                q.push_back(e);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_regwrite", 32'(RegWrite), 32'(m_we));
            chk("model_writereg", 32'(writereg), 32'(m_reg));
            chk("model_writedata", writedata, m_data);
            chk("model_count", 32'(fifo_count), 32'(q.size()));
            chk("model_ready", 32'(md_ready), 32'(q.size() < DEPTH));
            chk("model_pend_hit", 32'(pend_hit), 32'(model_hit(pend_q)));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(logic av, logic [4:0] ar, logic [31:0] ad,
                         logic mv, logic [4:0] mr, logic [31:0] md);
        alu_valid = av; alu_reg = ar; alu_data = ad;
        md_valid  = mv; md_reg  = mr; md_data  = md;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        pend_q = 5'd0;
        idle();
        step();
        step();
        rst = 1'b0;
        chk("rst_regwrite", 32'(RegWrite), 32'd0);
        chk("rst_writereg", 32'(writereg), 32'd0);
        chk("rst_writedata", writedata, 32'd0);
        chk("rst_count", 32'(fifo_count), 32'd0);
        chk("rst_ready", 32'(md_ready), 32'd1);
        chk("rst_pend_hit", 32'(pend_hit), 32'd0);
        chk_en = 1'b1;

        // ALU only
        drive(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'd0);
        step();
        chk("alu_we", 32'(RegWrite), 32'd1);
        chk("alu_reg", 32'(writereg), 32'd5);
        chk("alu_data", writedata, 32'h1234);
        chk("alu_ready", 32'(md_ready), 32'd1);
        idle();
        step();
        chk("alu_idle_we", 32'(RegWrite), 32'd0);
        chk("alu_hold_reg", 32'(writereg), 32'd5);

        // Fill under continuous ALU traffic, then drain in order
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 5'd9, 32'h100 + 32'(i), 1'b1, 5'(i), 32'hA0 + 32'(i));
            step();
        end
        chk("fill_count", 32'(fifo_count), 32'd4);
        chk("fill_ready", 32'(md_ready), 32'd0);
        chk("fill_writereg", 32'(writereg), 32'd9);
        pend_q = 5'd3;
        #1;
        chk("fill_pend_hit", 32'(pend_hit), 32'd1);
        idle();
        for (int i = 1; i <= 4; i++) begin
            step();
            chk("drain_we", 32'(RegWrite), 32'd1);
            chk("drain_reg", 32'(writereg), 32'(i));
            chk("drain_data", writedata, 32'hA0 + 32'(i));
            chk("drain_count", 32'(fifo_count), 32'(4 - i));
            chk("drain_ready", 32'(md_ready), 32'd1);
        end
        step();
        chk("drain_done_we", 32'(RegWrite), 32'd0);

        // Kill of an older queued write by an ALU write
        drive(1'b1, 5'd9, 32'd1, 1'b1, 5'd7, 32'hAA);
        step();
        drive(1'b1, 5'd9, 32'd2, 1'b1, 5'd3, 32'h33);
        step();
        chk("kill_pre_count", 32'(fifo_count), 32'd2);
        pend_q = 5'd7;
        #1;
        chk("kill_pre_hit", 32'(pend_hit), 32'd1);
        drive(1'b1, 5'd7, 32'h77, 1'b0, 5'd0, 32'd0);
        step();
        chk("kill_reg", 32'(writereg), 32'd7);
        chk("kill_data", writedata, 32'h77);
        chk("kill_count", 32'(fifo_count), 32'd1);
        chk("kill_hit", 32'(pend_hit), 32'd0);
        idle();
        step();
        chk("kill_surv_reg", 32'(writereg), 32'd3);
        chk("kill_surv_data", writedata, 32'h33);
        chk("kill_surv_count", 32'(fifo_count), 32'd0);
        step();
        chk("kill_end_we", 32'(RegWrite), 32'd0);

        // Zero register handling
        drive(1'b1, 5'd9, 32'd3, 1'b1, 5'd12, 32'hC);
        step();
        drive(1'b1, 5'd0, 32'h55, 1'b0, 5'd0, 32'd0);
        step();
        chk("r0alu_we", 32'(RegWrite), 32'd1);
        chk("r0alu_reg", 32'(writereg), 32'd12);
        chk("r0alu_data", writedata, 32'hC);
        chk("r0alu_count", 32'(fifo_count), 32'd0);
        drive(1'b1, 5'd9, 32'd4, 1'b1, 5'd0, 32'hDEAD);
        step();
        chk("r0md_count", 32'(fifo_count), 32'd0);
        chk("r0md_reg", 32'(writereg), 32'd9);
        idle();
        step();
        chk("r0md_we", 32'(RegWrite), 32'd0);

        // Same-cycle ALU write and md push to the same register
        drive(1'b1, 5'd9, 32'd5, 1'b1, 5'd20, 32'd1);
        step();
        drive(1'b1, 5'd20, 32'd2, 1'b1, 5'd20, 32'd3);
        step();
        chk("same_reg", 32'(writereg), 32'd20);
        chk("same_data", writedata, 32'd2);
        chk("same_count", 32'(fifo_count), 32'd1);
        idle();
        step();
        chk("same_new_reg", 32'(writereg), 32'd20);
        chk("same_new_data", writedata, 32'd3);
        chk("same_new_count", 32'(fifo_count), 32'd0);

        // Reset mid-operation with simultaneous traffic
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, 5'd9, 32'(i), 1'b1, 5'(i), 32'hB0 + 32'(i));
            step();
        end
        chk("mrst_pre_count", 32'(fifo_count), 32'd3);
        rst = 1'b1;
        drive(1'b1, 5'd6, 32'h66, 1'b1, 5'd4, 32'h44);
        step();
        chk("mrst_we", 32'(RegWrite), 32'd0);
        chk("mrst_reg", 32'(writereg), 32'd0);
        chk("mrst_data", writedata, 32'd0);
        chk("mrst_count", 32'(fifo_count), 32'd0);
        chk("mrst_ready", 32'(md_ready), 32'd1);
        rst = 1'b0;
        idle();
        pend_q = 5'd2;
        step();
        chk("mrst_after_we", 32'(RegWrite), 32'd0);
        chk("mrst_after_hit", 32'(pend_hit), 32'd0);
        chk("mrst_after_count", 32'(fifo_count), 32'd0);

        // Push and pop together at DEPTH-1 across the pointer wrap
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 5'd9, 32'(i), 1'b1, 5'(10 + i), 32'hC0 + 32'(i));
            step();
        end
        chk("wrap_fill_count", 32'(fifo_count), 32'd3);
        for (int k = 0; k < 5; k++) begin
            drive(1'b0, 5'd0, 32'd0, 1'b1, 5'(13 + k), 32'hC3 + 32'(k));
            step();
            chk("wrap_count", 32'(fifo_count), 32'd3);
            chk("wrap_reg", 32'(writereg), 32'(10 + k));
            chk("wrap_data", writedata, 32'hC0 + 32'(k));
        end
        idle();
        for (int k = 5; k < 8; k++) begin
            step();
            chk("wrap_drain_reg", 32'(writereg), 32'(10 + k));
            chk("wrap_drain_data", writedata, 32'hC0 + 32'(k));
        end
        step();
        chk("wrap_end_we", 32'(RegWrite), 32'd0);
        chk("wrap_end_count", 32'(fifo_count), 32'd0);

        @(negedge clk);
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
